// File: rtl/shift_pkg.sv
// Shared definitions for the serial transmitter and receiver:
// FSM state encoding, default frame geometry and counter sizing.
package shift_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 16;
  localparam int unsigned DEFAULT_DIV   = 4;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Bit-period tick generator.
// Counts 0..DIV-1 while enabled and flags the last count of each period.
// Ports:
//   clk_100MHz - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   clear      - synchronous restart of the period count
//   enable     - count only while high; holds otherwise
//   tick       - high during the final cycle of a bit period
module tick_gen
  import shift_pkg::*;
#(
  parameter int unsigned DIV = DEFAULT_DIV
) (
  input  logic clk_100MHz,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned   CW   = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Period counter; wraps at DIV-1 and never advances while disabled.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  // With DIV=1 the counter sits at 0 == LAST, so tick follows enable.
  assign tick = enable & ~clear & (cnt == LAST);

endmodule

// File: rtl/piso_shift_register.sv
// Parallel-in serial-out transmitter.
// Accepts a WIDTH-bit word when idle and shifts it out LSB first, holding
// each bit for DIV clock cycles, then pulses done for one cycle.
// Ports:
//   clk_100MHz  - clock, rising edge
//   rst_n       - asynchronous active-low reset
//   load        - start a frame (honoured only while ready)
//   parallel_in - frame word, sampled on an accepted load
//   ready       - a load will be accepted (inverse of busy)
//   serial_out  - registered serial stream, 0 when idle
//   busy        - registered, high while a frame is on the line
//   done        - registered one-cycle pulse at frame completion
module piso_shift_register
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DIV   = DEFAULT_DIV
) (
  input  logic             clk_100MHz,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] parallel_in,
  output logic             ready,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned    BCW      = cnt_width(WIDTH);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic             serial_d, busy_d, done_d;
  logic             tick, tick_clear;

  // Bit-period timing runs only while shifting.
  tick_gen #(
    .DIV(DIV)
  ) u_tick_gen (
    .clk_100MHz(clk_100MHz),
    .rst_n     (rst_n),
    .clear     (tick_clear),
    .enable    (state_q == SHIFT),
    .tick      (tick)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    serial_d   = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    tick_clear = 1'b0;

    case (state_q)
      IDLE: begin
        if (load) begin
          shreg_d    = parallel_in;
          bit_cnt_d  = '0;
          tick_clear = 1'b1;
          serial_d   = parallel_in[0];
          busy_d     = 1'b1;
          state_d    = SHIFT;
        end
      end

      SHIFT: begin
        // serial_out always mirrors the register LSB during a frame.
        serial_d = shreg_q[0];
        busy_d   = 1'b1;
        if (tick) begin
          if (bit_cnt_q != LAST_BIT) begin
            shreg_d   = {1'b0, shreg_q[WIDTH-1:1]};
            serial_d  = shreg_q[1];
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end else begin
            // Final tick: loads arriving now are dropped since state is SHIFT.
            state_d  = IDLE;
            serial_d = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      serial_out <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      serial_out <= serial_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  assign ready = ~busy;

endmodule
